// File: rtl/mem_bus_arbiter_if.sv
// Memory-bus bundle between N byte-wide masters, the arbiter, internal RAM and the HCI IO window.
// Latency: none, this is wiring only.
// Backpressure: none here; the arbiter grants one master per cycle and never stalls a memory.
//
// Signals:
//   m_req_in/m_wr_in/m_a_in/m_dout_in   per-master request, direction, packed address, packed write data
//   m_gnt_out/m_rvalid_out/m_din_out    one-hot grant, one-hot read-valid, shared read data
//   ram_*                               registered RAM command port plus RAM read data
//   io_*                                registered IO command port plus IO read data
//   busy_out                            reads still travelling through the return pipeline
// Modports: slave = arbiter view; master = environment view (masters plus the RAM/IO targets).
interface mem_bus_arbiter_if #(
   parameter int NUM_MASTERS    = 2,
   parameter int ADDR_WIDTH     = 32,
   parameter int RAM_ADDR_WIDTH = 17,
   parameter int IO_SEL_WIDTH   = 3
);
   logic [NUM_MASTERS-1:0]            m_req_in;
   logic [NUM_MASTERS-1:0]            m_wr_in;
   logic [NUM_MASTERS*ADDR_WIDTH-1:0] m_a_in;
   logic [NUM_MASTERS*8-1:0]          m_dout_in;
   logic [NUM_MASTERS-1:0]            m_gnt_out;
   logic [NUM_MASTERS-1:0]            m_rvalid_out;
   logic [7:0]                        m_din_out;

   logic                              ram_en_out;
   logic                              ram_r_nw_out;
   logic [RAM_ADDR_WIDTH-1:0]         ram_a_out;
   logic [7:0]                        ram_d_out;
   logic [7:0]                        ram_d_in;

   logic                              io_en_out;
   logic                              io_wr_out;
   logic [IO_SEL_WIDTH-1:0]           io_sel_out;
   logic [7:0]                        io_d_out;
   logic [7:0]                        io_d_in;

   logic                              busy_out;

   modport slave (
      input  m_req_in, m_wr_in, m_a_in, m_dout_in, ram_d_in, io_d_in,
      output m_gnt_out, m_rvalid_out, m_din_out,
             ram_en_out, ram_r_nw_out, ram_a_out, ram_d_out,
             io_en_out, io_wr_out, io_sel_out, io_d_out, busy_out
   );

   modport master (
      output m_req_in, m_wr_in, m_a_in, m_dout_in, ram_d_in, io_d_in,
      input  m_gnt_out, m_rvalid_out, m_din_out,
             ram_en_out, ram_r_nw_out, ram_a_out, ram_d_out,
             io_en_out, io_wr_out, io_sel_out, io_d_out, busy_out
   );
endinterface

// File: rtl/mem_bus_arbiter.sv
// Round-robin N-master byte bus arbiter with RAM/IO decode, debug override and tagged read return.
// Latency: grant combinational in t, command registered in t+1, read data in t+1+RD_LATENCY.
// Backpressure: none; one access per cycle, losers simply are not granted and may retry or drop req.
//
// Ports:
//   clk_in         system clock
//   rst_n_in       asynchronous reset, active low
//   dbg_active_in  debug break, only PRIO_MASTER may be granted while high
//   bus            mem_bus_arbiter_if.slave: master requests/grants, RAM and IO ports, busy_out
module mem_bus_arbiter #(
   parameter int NUM_MASTERS    = 2,
   parameter int ADDR_WIDTH     = 32,
   parameter int RAM_ADDR_WIDTH = 17,
   parameter int IO_SEL_WIDTH   = 3,
   parameter int PRIO_MASTER    = 0,
   parameter int RD_LATENCY     = 1
) (
   input  logic             clk_in,
   input  logic             rst_n_in,
   input  logic             dbg_active_in,
   mem_bus_arbiter_if.slave bus
);
   localparam int PTR_W = (NUM_MASTERS > 1) ? $clog2(NUM_MASTERS) : 1;
   // Pointer starts at the last master so master 0 is searched first after reset.
   localparam logic [PTR_W-1:0] RR_RESET = PTR_W'(NUM_MASTERS - 1);

   // ---------------- arbitration ----------------
   logic [PTR_W-1:0]        r_rr_ptr;
   logic [NUM_MASTERS-1:0]  w_prio_mask;
   logic [NUM_MASTERS-1:0]  w_elig;
   logic                    w_gnt_vld;
   logic [PTR_W-1:0]        w_gnt_idx;
   logic [NUM_MASTERS-1:0]  w_gnt;

   // (ptr + k) mod NUM_MASTERS for k in 1..NUM_MASTERS, kept at pointer width.
   function automatic logic [PTR_W-1:0] f_wrap(input logic [PTR_W-1:0] ptr, input int k);
      int s;
      s = int'(ptr) + k;
      if (s >= NUM_MASTERS) s = s - NUM_MASTERS;
      return s[PTR_W-1:0];
   endfunction

   assign w_prio_mask = NUM_MASTERS'(1) << PRIO_MASTER;
   assign w_elig      = dbg_active_in ? (bus.m_req_in & w_prio_mask) : bus.m_req_in;

   always_comb begin
      w_gnt_vld = 1'b0;
      w_gnt_idx = '0;
      for (int k = 1; k <= NUM_MASTERS; k++) begin
         if (!w_gnt_vld && w_elig[f_wrap(r_rr_ptr, k)]) begin
            w_gnt_vld = 1'b1;
            w_gnt_idx = f_wrap(r_rr_ptr, k);
         end
      end
   end

   assign w_gnt = w_gnt_vld ? (NUM_MASTERS'(1) << w_gnt_idx) : '0;

   always_ff @(posedge clk_in or negedge rst_n_in) begin
      if (!rst_n_in) begin
         r_rr_ptr <= RR_RESET;
      end else if (w_gnt_vld) begin
         r_rr_ptr <= w_gnt_idx;
      end
   end

   // ---------------- granted master field select ----------------
   // Only the bits the decoder looks at are pulled out; upper address bits are ignored.
   logic [RAM_ADDR_WIDTH:0] w_sel_a;
   logic                    w_sel_wr;
   logic [7:0]              w_sel_d;
   logic                    w_is_io;

   always_comb begin
      w_sel_a  = '0;
      w_sel_wr = 1'b0;
      w_sel_d  = '0;
      for (int i = 0; i < NUM_MASTERS; i++) begin
         if (w_gnt[i]) begin
            w_sel_a  = bus.m_a_in[i*ADDR_WIDTH +: RAM_ADDR_WIDTH+1];
            w_sel_wr = bus.m_wr_in[i];
            w_sel_d  = bus.m_dout_in[i*8 +: 8];
         end
      end
   end

   assign w_is_io = (w_sel_a[RAM_ADDR_WIDTH -: 2] == 2'b11);

   // ---------------- issue registers ----------------
   logic                      r_ram_en;
   logic                      r_ram_r_nw;
   logic [RAM_ADDR_WIDTH-1:0] r_ram_a;
   logic [7:0]                r_ram_d;
   logic                      r_io_en;
   logic                      r_io_wr;
   logic [IO_SEL_WIDTH-1:0]   r_io_sel;
   logic [7:0]                r_io_d;

   always_ff @(posedge clk_in or negedge rst_n_in) begin
      if (!rst_n_in) begin
         r_ram_en   <= 1'b0;
         r_ram_r_nw <= 1'b0;
         r_ram_a    <= '0;
         r_ram_d    <= '0;
         r_io_en    <= 1'b0;
         r_io_wr    <= 1'b0;
         r_io_sel   <= '0;
         r_io_d     <= '0;
      end else begin
         r_ram_en <= w_gnt_vld && !w_is_io;
         r_io_en  <= w_gnt_vld &&  w_is_io;
         // Command fields hold their last value when their enable is low.
         if (w_gnt_vld && !w_is_io) begin
            r_ram_r_nw <= !w_sel_wr;
            r_ram_a    <= w_sel_a[RAM_ADDR_WIDTH-1:0];
            r_ram_d    <= w_sel_d;
         end
         if (w_gnt_vld && w_is_io) begin
            r_io_wr  <= w_sel_wr;
            r_io_sel <= w_sel_a[IO_SEL_WIDTH-1:0];
            r_io_d   <= w_sel_d;
         end
      end
   end

   // ---------------- read tag pipeline ----------------
   // Stage 0 is live in the issue cycle; stage RD_LATENCY lines up with the target's read data.
   logic [RD_LATENCY:0]            r_tag_vld;
   logic [RD_LATENCY:0]            r_tag_io;
   logic [RD_LATENCY:0][PTR_W-1:0] r_tag_id;

   always_ff @(posedge clk_in or negedge rst_n_in) begin
      if (!rst_n_in) begin
         r_tag_vld <= '0;
         r_tag_io  <= '0;
         r_tag_id  <= '0;
      end else begin
         r_tag_vld <= {r_tag_vld[RD_LATENCY-1:0], w_gnt_vld && !w_sel_wr};
         r_tag_io  <= {r_tag_io[RD_LATENCY-1:0], w_is_io};
         r_tag_id  <= {r_tag_id[RD_LATENCY-1:0], w_gnt_idx};
      end
   end

   logic w_ret_vld;
   assign w_ret_vld = r_tag_vld[RD_LATENCY];

   // ---------------- outputs ----------------
   assign bus.m_gnt_out    = w_gnt;
   assign bus.m_rvalid_out = w_ret_vld ? (NUM_MASTERS'(1) << r_tag_id[RD_LATENCY]) : '0;
   assign bus.m_din_out    = !w_ret_vld ? 8'h00 :
                             (r_tag_io[RD_LATENCY] ? bus.io_d_in : bus.ram_d_in);
   assign bus.busy_out     = |r_tag_vld;

   assign bus.ram_en_out   = r_ram_en;
   assign bus.ram_r_nw_out = r_ram_r_nw;
   assign bus.ram_a_out    = r_ram_a;
   assign bus.ram_d_out    = r_ram_d;
   assign bus.io_en_out    = r_io_en;
   assign bus.io_wr_out    = r_io_wr;
   assign bus.io_sel_out   = r_io_sel;
   assign bus.io_d_out     = r_io_d;
endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Directed bench: 2-master/latency-1 instance driven from a per-cycle vector table, plus
// hand sequences for async reset mid-read and a 4-master/latency-3 instance.
// Memory models: RAM byte = addr[7:0]^0xB5 after reset, IO reg i = 0xC0|i; both writable.
module tb_mem_bus_arbiter;
   logic clk;
   logic rst_n;
   logic dbg_a;
   logic dbg_b;

   int n_total = 0;
   int n_pass  = 0;

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   mem_bus_arbiter_if #(.NUM_MASTERS(2)) ifa();
   mem_bus_arbiter_if #(.NUM_MASTERS(4)) ifb();

   mem_bus_arbiter #(.NUM_MASTERS(2), .RD_LATENCY(1)) dut_a (
      .clk_in(clk), .rst_n_in(rst_n), .dbg_active_in(dbg_a), .bus(ifa));
   mem_bus_arbiter #(.NUM_MASTERS(4), .RD_LATENCY(3)) dut_b (
      .clk_in(clk), .rst_n_in(rst_n), .dbg_active_in(dbg_b), .bus(ifb));

   // ---------------- target models ----------------
   logic [7:0] a_mem [256];
   logic [7:0] a_io  [8];
   logic [7:0] a_ram_q, a_io_q;
   logic [7:0] b_mem [256];
   logic [7:0] b_io  [8];
   logic [7:0] b_ram_p [3];
   logic [7:0] b_io_p  [3];

   assign ifa.ram_d_in = a_ram_q;
   assign ifa.io_d_in  = a_io_q;
   assign ifb.ram_d_in = b_ram_p[2];
   assign ifb.io_d_in  = b_io_p[2];

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < 256; i++) a_mem[i] <= 8'(i) ^ 8'hB5;
         for (int i = 0; i < 8; i++)   a_io[i]  <= 8'hC0 | 8'(i);
         a_ram_q <= 8'h00;
         a_io_q  <= 8'h00;
      end else begin
         if (ifa.ram_en_out) begin
            if (ifa.ram_r_nw_out) a_ram_q <= a_mem[ifa.ram_a_out[7:0]];
            else                  a_mem[ifa.ram_a_out[7:0]] <= ifa.ram_d_out;
         end
         if (ifa.io_en_out) begin
            if (ifa.io_wr_out) a_io[ifa.io_sel_out] <= ifa.io_d_out;
            else               a_io_q <= a_io[ifa.io_sel_out];
         end
      end
   end

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < 256; i++) b_mem[i] <= 8'(i) ^ 8'hB5;
         for (int i = 0; i < 8; i++)   b_io[i]  <= 8'hC0 | 8'(i);
         for (int i = 0; i < 3; i++) begin
            b_ram_p[i] <= 8'h00;
            b_io_p[i]  <= 8'h00;
         end
      end else begin
         b_ram_p[1] <= b_ram_p[0];
         b_ram_p[2] <= b_ram_p[1];
         b_io_p[1]  <= b_io_p[0];
         b_io_p[2]  <= b_io_p[1];
         if (ifb.ram_en_out) begin
            if (ifb.ram_r_nw_out) b_ram_p[0] <= b_mem[ifb.ram_a_out[7:0]];
            else                  b_mem[ifb.ram_a_out[7:0]] <= ifb.ram_d_out;
         end
         if (ifb.io_en_out) begin
            if (ifb.io_wr_out) b_io[ifb.io_sel_out] <= ifb.io_d_out;
            else               b_io_p[0] <= b_io[ifb.io_sel_out];
         end
      end
   end

   // ---------------- checking ----------------
   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_total++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
   endtask

   typedef struct {
      logic        dbg;
      logic [1:0]  req;
      logic [1:0]  wr;
      logic [31:0] a0;
      logic [31:0] a1;
      logic [7:0]  d0;
      logic [7:0]  d1;
      logic [1:0]  e_gnt;
      logic        e_ram_en;
      logic        e_rnw;
      logic [16:0] e_ram_a;
      logic [7:0]  e_ram_d;
      logic        e_io_en;
      logic        e_io_wr;
      logic [2:0]  e_io_sel;
      logic [7:0]  e_io_d;
      logic [1:0]  e_rv;
      logic [7:0]  e_din;
      logic        e_busy;
   } vec_t;

   localparam int NV = 28;
   vec_t vec [NV];

   initial begin
      #100000;
      $fatal(1, "FAIL watchdog: simulation did not finish in time");
   end

   initial begin
      // dbg req  wr   a0          a1           d0     d1   | gnt ren rnw ram_a     ram_d ioen iowr sel iod   rv     din    busy
      vec[0]  = '{0, 2'b01, 2'b00, 32'h10,    32'h0,        8'h00, 8'h00, 2'b01, 0, 0, 17'h0,  8'h00, 0, 0, 3'd0, 8'h00, 2'b00, 8'h00, 0};
      vec[1]  = '{0, 2'b00, 2'b00, 32'h0,     32'h0,        8'h00, 8'h00, 2'b00, 1, 1, 17'h10, 8'h00, 0, 0, 3'd0, 8'h00, 2'b00, 8'h00, 1};
      vec[2]  = '{0, 2'b00, 2'b00, 32'h0,     32'h0,        8'h00, 8'h00, 2'b00, 0, 0, 17'h0,  8'h00, 0, 0, 3'd0, 8'h00, 2'b01, 8'hA5, 1};
      vec[3]  = '{0, 2'b10, 2'b10, 32'h0,     32'h30004,    8'h00, 8'h5A, 2'b10, 0, 0, 17'h0,  8'h00, 0, 0, 3'd0, 8'h00, 2'b00, 8'h00, 0};
      vec[4]  = '{0, 2'b00, 2'b00, 32'h0,     32'h0,        8'h00, 8'h00, 2'b00, 0, 0, 17'h0,  8'h00, 1, 1, 3'd4, 8'h5A, 2'b00, 8'h00, 0};
      vec[5]  = '{0, 2'b00, 2'b00, 32'h0,     32'h0,        8'h00, 8'h00, 2'b00, 0, 0, 17'h0,  8'h00, 0, 0, 3'd0, 8'h00, 2'b00, 8'h00, 0};
      vec[6]  = '{0, 2'b11, 2'b00, 32'h20,    32'h21,       8'h00, 8'h00, 2'b01, 0, 0, 17'h0,  8'h00, 0, 0, 3'd0, 8'h00, 2'b00, 8'h00, 0};
      vec[7]  = '{0, 2'b11, 2'b00, 32'h20,    32'h21,       8'h00, 8'h00, 2'b10, 1, 1, 17'h20, 8'h00, 0, 0, 3'd0, 8'h00, 2'b00, 8'h00, 1};
      vec[8]  = '{0, 2'b11, 2'b00, 32'h20,    32'h21,       8'h00, 8'h00, 2'b01, 1, 1, 17'h21, 8'h00, 0, 0, 3'd0, 8'h00, 2'b01, 8'h95, 1};
      vec[9]  = '{0, 2'b11, 2'b00, 32'h20,    32'h21,       8'h00, 8'h00, 2'b10, 1, 1, 17'h20, 8'h00, 0, 0, 3'd0, 8'h00, 2'b10, 8'h94, 1};
      vec[10] = '{0, 2'b11, 2'b00, 32'h20,    32'h21,       8'h00, 8'h00, 2'b01, 1, 1, 17'h21, 8'h00, 0, 0, 3'd0, 8'h00, 2'b01, 8'h95, 1};
      vec[11] = '{0, 2'b11, 2'b00, 32'h20,    32'h21,       8'h00, 8'h00, 2'b10, 1, 1, 17'h20, 8'h00, 0, 0, 3'd0, 8'h00, 2'b10, 8'h94, 1};
      vec[12] = '{0, 2'b00, 2'b00, 32'h0,     32'h0,        8'h00, 8'h00, 2'b00, 1, 1, 17'h21, 8'h00, 0, 0, 3'd0, 8'h00, 2'b01, 8'h95, 1};
      vec[13] = '{0, 2'b00, 2'b00, 32'h0,     32'h0,        8'h00, 8'h00, 2'b00, 0, 0, 17'h0,  8'h00, 0, 0, 3'd0, 8'h00, 2'b10, 8'h94, 1};
      vec[14] = '{0, 2'b00, 2'b00, 32'h0,     32'h0,        8'h00, 8'h00, 2'b00, 0, 0, 17'h0,  8'h00, 0, 0, 3'd0, 8'h00, 2'b00, 8'h00, 0};
      vec[15] = '{0, 2'b10, 2'b00, 32'h0,     32'h30002,    8'h00, 8'h00, 2'b10, 0, 0, 17'h0,  8'h00, 0, 0, 3'd0, 8'h00, 2'b00, 8'h00, 0};
      vec[16] = '{1, 2'b11, 2'b00, 32'h22,    32'h30002,    8'h00, 8'h00, 2'b01, 0, 0, 17'h0,  8'h00, 1, 0, 3'd2, 8'h00, 2'b00, 8'h00, 1};
      vec[17] = '{1, 2'b11, 2'b00, 32'h22,    32'h30002,    8'h00, 8'h00, 2'b01, 1, 1, 17'h22, 8'h00, 0, 0, 3'd0, 8'h00, 2'b10, 8'hC2, 1};
      vec[18] = '{1, 2'b11, 2'b00, 32'h22,    32'h30002,    8'h00, 8'h00, 2'b01, 1, 1, 17'h22, 8'h00, 0, 0, 3'd0, 8'h00, 2'b01, 8'h97, 1};
      vec[19] = '{0, 2'b11, 2'b00, 32'h22,    32'h30002,    8'h00, 8'h00, 2'b10, 1, 1, 17'h22, 8'h00, 0, 0, 3'd0, 8'h00, 2'b01, 8'h97, 1};
      vec[20] = '{0, 2'b00, 2'b00, 32'h0,     32'h0,        8'h00, 8'h00, 2'b00, 0, 0, 17'h0,  8'h00, 1, 0, 3'd2, 8'h00, 2'b01, 8'h97, 1};
      vec[21] = '{0, 2'b00, 2'b00, 32'h0,     32'h0,        8'h00, 8'h00, 2'b00, 0, 0, 17'h0,  8'h00, 0, 0, 3'd0, 8'h00, 2'b10, 8'hC2, 1};
      vec[22] = '{0, 2'b01, 2'b01, 32'h40,    32'h0,        8'h33, 8'h00, 2'b01, 0, 0, 17'h0,  8'h00, 0, 0, 3'd0, 8'h00, 2'b00, 8'h00, 0};
      vec[23] = '{0, 2'b10, 2'b00, 32'h0,     32'hFFF00040, 8'h00, 8'h00, 2'b10, 1, 0, 17'h40, 8'h33, 0, 0, 3'd0, 8'h00, 2'b00, 8'h00, 0};
      vec[24] = '{0, 2'b01, 2'b00, 32'h20050, 32'h0,        8'h00, 8'h00, 2'b01, 1, 1, 17'h40, 8'h00, 0, 0, 3'd0, 8'h00, 2'b00, 8'h00, 1};
      vec[25] = '{0, 2'b00, 2'b00, 32'h0,     32'h0,        8'h00, 8'h00, 2'b00, 1, 1, 17'h50, 8'h00, 0, 0, 3'd0, 8'h00, 2'b10, 8'h33, 1};
      vec[26] = '{0, 2'b00, 2'b00, 32'h0,     32'h0,        8'h00, 8'h00, 2'b00, 0, 0, 17'h0,  8'h00, 0, 0, 3'd0, 8'h00, 2'b01, 8'hE5, 1};
      vec[27] = '{0, 2'b00, 2'b00, 32'h0,     32'h0,        8'h00, 8'h00, 2'b00, 0, 0, 17'h0,  8'h00, 0, 0, 3'd0, 8'h00, 2'b00, 8'h00, 0};

      // ---------------- reset state ----------------
      rst_n = 1'b0;
      dbg_a = 1'b0;
      dbg_b = 1'b0;
      ifa.m_req_in = 2'b11;  ifa.m_wr_in = '0; ifa.m_a_in = '0; ifa.m_dout_in = '0;
      ifb.m_req_in = 4'b0000; ifb.m_wr_in = '0; ifb.m_a_in = '0; ifb.m_dout_in = '0;
      #22;
      chk("rst gnt_a", 32'(ifa.m_gnt_out), 32'h1);
      chk("rst ram_en", 32'(ifa.ram_en_out), 32'h0);
      chk("rst io_en", 32'(ifa.io_en_out), 32'h0);
      chk("rst ram_a", 32'(ifa.ram_a_out), 32'h0);
      chk("rst io_d", 32'(ifa.io_d_out), 32'h0);
      chk("rst rvalid", 32'(ifa.m_rvalid_out), 32'h0);
      chk("rst din", 32'(ifa.m_din_out), 32'h0);
      chk("rst busy", 32'(ifa.busy_out), 32'h0);
      chk("rst b ram_en", 32'(ifb.ram_en_out), 32'h0);
      ifa.m_req_in = 2'b00;
      @(negedge clk);
      rst_n = 1'b1;

      // ---------------- table-driven sequence on instance A ----------------
      for (int i = 0; i < NV; i++) begin
         @(posedge clk);
         #1;
         dbg_a         = vec[i].dbg;
         ifa.m_req_in  = vec[i].req;
         ifa.m_wr_in   = vec[i].wr;
         ifa.m_a_in    = {vec[i].a1, vec[i].a0};
         ifa.m_dout_in = {vec[i].d1, vec[i].d0};
         @(negedge clk);
         chk($sformatf("r%0d gnt", i),    32'(ifa.m_gnt_out),    32'(vec[i].e_gnt));
         chk($sformatf("r%0d ram_en", i), 32'(ifa.ram_en_out),   32'(vec[i].e_ram_en));
         chk($sformatf("r%0d io_en", i),  32'(ifa.io_en_out),    32'(vec[i].e_io_en));
         chk($sformatf("r%0d rvalid", i), 32'(ifa.m_rvalid_out), 32'(vec[i].e_rv));
         chk($sformatf("r%0d din", i),    32'(ifa.m_din_out),    32'(vec[i].e_din));
         chk($sformatf("r%0d busy", i),   32'(ifa.busy_out),     32'(vec[i].e_busy));
         if (vec[i].e_ram_en) begin
            chk($sformatf("r%0d ram_r_nw", i), 32'(ifa.ram_r_nw_out), 32'(vec[i].e_rnw));
            chk($sformatf("r%0d ram_a", i),    32'(ifa.ram_a_out),    32'(vec[i].e_ram_a));
            if (!vec[i].e_rnw)
               chk($sformatf("r%0d ram_d", i), 32'(ifa.ram_d_out), 32'(vec[i].e_ram_d));
         end
         if (vec[i].e_io_en) begin
            chk($sformatf("r%0d io_wr", i),  32'(ifa.io_wr_out),  32'(vec[i].e_io_wr));
            chk($sformatf("r%0d io_sel", i), 32'(ifa.io_sel_out), 32'(vec[i].e_io_sel));
            if (vec[i].e_io_wr)
               chk($sformatf("r%0d io_d", i), 32'(ifa.io_d_out), 32'(vec[i].e_io_d));
         end
      end

      // ---------------- async reset with a read in flight ----------------
      @(posedge clk); #1;
      ifa.m_req_in = 2'b01; ifa.m_wr_in = 2'b00; ifa.m_a_in = {32'h0, 32'h10};
      @(negedge clk);
      chk("rstfly gnt", 32'(ifa.m_gnt_out), 32'h1);
      @(posedge clk); #1;
      ifa.m_req_in = 2'b00;
      @(negedge clk);
      chk("rstfly ram_en", 32'(ifa.ram_en_out), 32'h1);
      chk("rstfly busy", 32'(ifa.busy_out), 32'h1);
      #1 rst_n = 1'b0;
      #1;
      chk("rstfly async ram_en", 32'(ifa.ram_en_out), 32'h0);
      chk("rstfly async busy", 32'(ifa.busy_out), 32'h0);
      chk("rstfly async io_en", 32'(ifa.io_en_out), 32'h0);
      @(posedge clk); #1;
      chk("rstfly rvalid in rst", 32'(ifa.m_rvalid_out), 32'h0);
      chk("rstfly din in rst", 32'(ifa.m_din_out), 32'h0);
      @(negedge clk);
      rst_n = 1'b1;
      for (int c = 0; c < 3; c++) begin
         @(negedge clk);
         chk($sformatf("rstfly rvalid c%0d", c), 32'(ifa.m_rvalid_out), 32'h0);
         chk($sformatf("rstfly busy c%0d", c), 32'(ifa.busy_out), 32'h0);
      end
      @(posedge clk); #1;
      ifa.m_req_in = 2'b11;
      @(negedge clk);
      chk("rstfly rr restart gnt", 32'(ifa.m_gnt_out), 32'h1);
      @(posedge clk); #1;
      ifa.m_req_in = 2'b00;

      // ---------------- 4 masters, read latency 3 ----------------
      ifb.m_wr_in = 4'b0000;
      ifb.m_a_in  = {32'h11, 32'h30001, 32'h12, 32'h0};
      @(posedge clk); #1;
      ifb.m_req_in = 4'b1000;
      @(negedge clk);
      chk("b c0 gnt", 32'(ifb.m_gnt_out), 32'h8);
      @(posedge clk); #1;
      ifb.m_req_in = 4'b0010;
      @(negedge clk);
      chk("b c1 gnt", 32'(ifb.m_gnt_out), 32'h2);
      chk("b c1 ram_en", 32'(ifb.ram_en_out), 32'h1);
      chk("b c1 ram_a", 32'(ifb.ram_a_out), 32'h11);
      @(posedge clk); #1;
      ifb.m_req_in = 4'b0100;
      @(negedge clk);
      chk("b c2 gnt", 32'(ifb.m_gnt_out), 32'h4);
      chk("b c2 ram_a", 32'(ifb.ram_a_out), 32'h12);
      @(posedge clk); #1;
      ifb.m_req_in = 4'b0000;
      @(negedge clk);
      chk("b c3 io_en", 32'(ifb.io_en_out), 32'h1);
      chk("b c3 io_sel", 32'(ifb.io_sel_out), 32'h1);
      chk("b c3 ram_en", 32'(ifb.ram_en_out), 32'h0);
      chk("b c3 rvalid", 32'(ifb.m_rvalid_out), 32'h0);
      chk("b c3 busy", 32'(ifb.busy_out), 32'h1);
      @(negedge clk);
      chk("b c4 rvalid", 32'(ifb.m_rvalid_out), 32'h8);
      chk("b c4 din", 32'(ifb.m_din_out), 32'hA4);
      @(negedge clk);
      chk("b c5 rvalid", 32'(ifb.m_rvalid_out), 32'h2);
      chk("b c5 din", 32'(ifb.m_din_out), 32'hA7);
      @(negedge clk);
      chk("b c6 rvalid", 32'(ifb.m_rvalid_out), 32'h4);
      chk("b c6 din", 32'(ifb.m_din_out), 32'hC1);
      @(negedge clk);
      chk("b c7 rvalid", 32'(ifb.m_rvalid_out), 32'h0);
      chk("b c7 busy", 32'(ifb.busy_out), 32'h0);
      // Last grant was M2, so a full contest goes to M3 then wraps to M0.
      @(posedge clk); #1;
      ifb.m_req_in = 4'b1111;
      @(negedge clk);
      chk("b rr wrap gnt0", 32'(ifb.m_gnt_out), 32'h8);
      @(posedge clk); #1;
      @(negedge clk);
      chk("b rr wrap gnt1", 32'(ifb.m_gnt_out), 32'h1);
      @(posedge clk); #1;
      ifb.m_req_in = 4'b0000;
      repeat (5) @(posedge clk);

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end
endmodule
